// File: rtl/pio_poll_master.sv
// Avalon-MM read initiator that polls a 1-bit PIO and debounces the selected readdata bit.
// Optional edge counter output enabled by defining PIO_POLL_EDGE_COUNT_EN.
module pio_poll_master #(
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int READ_LATENCY = 1,
  parameter int BIT_SEL      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        level,
  output logic        rise_pulse,
  output logic        fall_pulse,
  output logic        sample_valid
`ifdef PIO_POLL_EDGE_COUNT_EN
  ,
  input  logic        edge_count_clr,
  output logic [15:0] edge_count
`endif
);

  // state      | meaning
  // ST_IDLE    | poll timer runs while enable=1, held at 0 otherwise
  // ST_REQ     | single-cycle read strobe
  // ST_WAIT    | remaining READ_LATENCY-1 cycles of responder latency
  // ST_CAPTURE | readdata valid, sample taken and debounced

  localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int WW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [CW-1:0]   stable_q;
  logic            sample;
  logic            unused_readdata;

  assign sample          = avm_readdata[BIT_SEL];
  assign unused_readdata = ^avm_readdata;
  assign avm_address     = 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    wait_d   = wait_q;
    avm_read = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          state_d = ST_REQ;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_REQ: begin
        avm_read = 1'b1;
        state_d  = (READ_LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = ST_CAPTURE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A sample equal to the current level restarts the stability run.
  always_ff @(posedge clk) begin
    if (reset) begin
      level        <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      sample_valid <= 1'b0;
      stable_q     <= '0;
    end else begin
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      sample_valid <= (state_q == ST_CAPTURE);
      if (state_q == ST_CAPTURE) begin
        if (sample != level) begin
          if (stable_q == CNT_LAST) begin
            level      <= sample;
            stable_q   <= '0;
            rise_pulse <= sample;
            fall_pulse <= ~sample;
          end else begin
            stable_q <= stable_q + 1'b1;
          end
        end else begin
          stable_q <= '0;
        end
      end
    end
  end

`ifdef PIO_POLL_EDGE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_count <= 16'd0;
    end else if (edge_count_clr) begin
      edge_count <= 16'd0;
    end else if (rise_pulse || fall_pulse) begin
      edge_count <= edge_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pio_poll_master.sv
// Bench for pio_poll_master: phase/debounce model checked every cycle plus pinned cycle numbers.
// Covers the PIO_POLL_EDGE_COUNT_EN build when that macro is defined.
module tb_pio_poll_master;
  localparam int POLL_DIV = 4;
  localparam int DEB      = 3;
  localparam int RL       = 1;
  localparam int BIT      = 0;
  localparam int CAP_PH   = POLL_DIV + RL;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        line = 1'b0;
  logic [30:0] junk = '0;
  logic [31:0] avm_readdata;
  logic [1:0]  avm_address;
  logic        avm_read, level, rise_pulse, fall_pulse, sample_valid;
  logic        edge_count_clr = 1'b0;
`ifdef PIO_POLL_EDGE_COUNT_EN
  logic [15:0] edge_count;
`endif

  int checks = 0;
  int failures = 0;

  // model: p is the position within the poll period (0..POLL_DIV-1 idle count, POLL_DIV read, CAP_PH capture)
  int p = 0, m_cnt = 0, m_ec = 0, cyc = 0;
  bit m_level = 0, m_rise = 0, m_fall = 0, m_sv = 0, model_ok = 0, s;
  int rd_q[$], sv_q[$], rise_q[$], fall_q[$];

  typedef struct {int len; bit en; bit ln; bit rst;} seg_t;
  seg_t segs[10] = '{'{20,1,1,0}, '{7,1,0,0}, '{30,1,0,0}, '{9,0,1,0}, '{40,1,1,0},
                     '{3,1,1,1}, '{50,1,0,0}, '{25,1,1,0}, '{13,0,0,0}, '{60,1,0,0}};

  always #5 clk = ~clk;

  always_comb begin
    avm_readdata      = {1'b0, junk};
    avm_readdata[BIT] = line;
  end

  pio_poll_master #(.POLL_DIV(POLL_DIV), .DEBOUNCE_CNT(DEB), .READ_LATENCY(RL), .BIT_SEL(BIT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .sample_valid(sample_valid)
`ifdef PIO_POLL_EDGE_COUNT_EN
    , .edge_count_clr(edge_count_clr), .edge_count(edge_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      p = 0; m_level = 0; m_cnt = 0; m_rise = 0; m_fall = 0; m_sv = 0; m_ec = 0;
      model_ok = 1; cyc = 0;
    end else begin
      cyc++;
      if (edge_count_clr) m_ec = 0;
      else if (m_rise || m_fall) m_ec = (m_ec + 1) % 65536;
      m_rise = 0; m_fall = 0; m_sv = 0;
      if (p == CAP_PH) begin
        s = avm_readdata[BIT];
        m_sv = 1;
        if (s != m_level) begin
          m_cnt++;
          if (m_cnt == DEB) begin
            m_level = s; m_cnt = 0;
            if (s) m_rise = 1; else m_fall = 1;
          end
        end else m_cnt = 0;
        p = 0;
      end else if (p < POLL_DIV) p = enable ? p + 1 : 0;
      else p++;
    end
  end

  always @(negedge clk) begin
    junk = 31'($urandom);
    if (model_ok) begin
      check("avm_read", avm_read, (p == POLL_DIV));
      check("avm_address", avm_address, 0);
      check("level", level, m_level);
      check("rise_pulse", rise_pulse, m_rise);
      check("fall_pulse", fall_pulse, m_fall);
      check("sample_valid", sample_valid, m_sv);
`ifdef PIO_POLL_EDGE_COUNT_EN
      check("edge_count", edge_count, m_ec);
`endif
      if (avm_read) rd_q.push_back(cyc);
      if (sample_valid) sv_q.push_back(cyc);
      if (rise_pulse) rise_q.push_back(cyc);
      if (fall_pulse) fall_q.push_back(cyc);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    rd_q.delete(); sv_q.delete(); rise_q.delete(); fall_q.delete();
    reset = 1'b0;
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int exp_rd[3];
    int exp_sv[3];
    exp_rd = '{4, 10, 16};
    exp_sv = '{6, 12, 18};

    // poll timing with a quiet line
    do_reset();
    enable = 1'b1; line = 1'b0;
    to_cyc(20);
    check("timing_rd_n", rd_q.size(), 3);
    check("timing_sv_n", sv_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rd_q.size()) check("timing_rd_cyc", rd_q[i], exp_rd[i]);
      if (i < sv_q.size()) check("timing_sv_cyc", sv_q[i], exp_sv[i]);
    end
    check("timing_pulses", rise_q.size() + fall_q.size(), 0);

    // rise after three captures
    do_reset();
    enable = 1'b1; line = 1'b1;
    to_cyc(20);
    check("rise_n", rise_q.size(), 1);
    if (rise_q.size() > 0) check("rise_cyc", rise_q[0], 18);
    check("rise_level", level, 1);

    // glitch for two captures, then a clean rise and a fall
    do_reset();
    enable = 1'b1; line = 1'b1;
    to_cyc(12); line = 1'b0;
    to_cyc(18); line = 1'b1;
    to_cyc(38);
    check("glitch_rise_n", rise_q.size(), 1);
    if (rise_q.size() > 0) check("glitch_rise_cyc", rise_q[0], 36);
    line = 1'b0;
    to_cyc(54);
    check("fall_pulse_cyc54", fall_pulse, 1);
    check("fall_level_cyc54", level, 0);
    to_cyc(58);
    check("fall_n", fall_q.size(), 1);
    if (fall_q.size() > 0) check("fall_cyc", fall_q[0], 54);
`ifdef PIO_POLL_EDGE_COUNT_EN
    check("ec_rise_fall", edge_count, 2);
    line = 1'b1;
    to_cyc(72);
    edge_count_clr = 1'b1;
    to_cyc(73);
    edge_count_clr = 1'b0;
    to_cyc(74);
    check("ec_clr_wins", edge_count, 0);
    force dut.edge_count = 16'hffff;
    m_ec = 65535;
    @(negedge clk);
    release dut.edge_count;
    line = 1'b0;
    to_cyc(92);
    check("ec_wrap", edge_count, 0);
`endif

    // enable dropped during the read request
    do_reset();
    enable = 1'b1; line = 1'b1;
    to_cyc(4); enable = 1'b0;
    to_cyc(30);
    check("en_rd_n", rd_q.size(), 1);
    check("en_sv_n", sv_q.size(), 1);
    if (sv_q.size() > 0) check("en_sv_cyc", sv_q[0], 6);
    enable = 1'b1;
    to_cyc(36);
    check("en_resume_n", rd_q.size(), 2);
    if (rd_q.size() > 1) check("en_resume_cyc", rd_q[1], 34);

    // reset during the read request
    do_reset();
    enable = 1'b1; line = 1'b1;
    to_cyc(4);
    check("rst_pre_read", avm_read, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_read", avm_read, 0);
    check("rst_outs", {level, rise_pulse, fall_pulse, sample_valid}, 0);
    reset = 1'b0;

    // directed enable/line/reset segments checked by the model
    do_reset();
    foreach (segs[i]) begin
      enable = segs[i].en; line = segs[i].ln; reset = segs[i].rst;
      repeat (segs[i].len) @(negedge clk);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
